// File: rtl/vga_vram_arbiter.sv
// vga_vram_arbiter
//   Shares one single-port synchronous video RAM between display scan-out and a
//   CPU write port. Every fourth pixel clock inside the active area is a display
//   fetch slot. All other cycles can carry a CPU write. The output is a
//   registered 4-bit pixel stream.
//
// Ports
//   CLK, CLR_N             pixel clock; synchronous active-low reset
//   HC, VC, VIDON          counters and active flag from the timing generator
//   CPU_REQ/ADDR/WDATA     write request; held stable until CPU_ACK
//   CPU_ACK                one-cycle pulse when the request is consumed
//   RAM_ADDR/WDATA/WE      registered RAM command
//   RAM_RDATA              RAM read data, valid one cycle after RAM samples ADDR
//   PIX, PIX_VALID         registered pixel (0 when blank) and VIDON delayed by 1
module vga_vram_arbiter #(
  parameter int unsigned HBP    = 144,
  parameter int unsigned HFP    = 784,
  parameter int unsigned VBP    = 31,
  parameter int unsigned VFP    = 511,
  parameter int unsigned ADDR_W = 17,
  parameter int unsigned WORDS  = 76800
) (
  input  logic              CLK,
  input  logic              CLR_N,
  input  logic [9:0]        HC,
  input  logic [9:0]        VC,
  input  logic              VIDON,
  input  logic              CPU_REQ,
  input  logic [ADDR_W-1:0] CPU_ADDR,
  input  logic [15:0]       CPU_WDATA,
  output logic              CPU_ACK,
  output logic [ADDR_W-1:0] RAM_ADDR,
  output logic [15:0]       RAM_WDATA,
  output logic              RAM_WE,
  input  logic [15:0]       RAM_RDATA,
  output logic [3:0]        PIX,
  output logic              PIX_VALID
);

  localparam int unsigned CNT_W = 10;

  localparam logic [CNT_W-1:0]  SLOT_LO   = CNT_W'(HBP - 4);
  localparam logic [CNT_W-1:0]  SLOT_HI   = CNT_W'(HFP - 4);
  localparam logic [CNT_W-1:0]  VBP_C     = CNT_W'(VBP);
  localparam logic [CNT_W-1:0]  VFP_C     = CNT_W'(VFP);
  localparam logic [1:0]        HBP_LO    = 2'(HBP);
  localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(WORDS - 1);
  localparam logic [ADDR_W:0]   WORDS_C   = (ADDR_W + 1)'(WORDS);

  // Registered state
  logic [ADDR_W-1:0] faddr_q, faddr_d;
  logic              slot_p1_q, slot_p1_d;
  logic              slot_p2_q, slot_p2_d;
  logic [15:0]       hold_q, hold_d;
  logic [11:0]       shift_q, shift_d;
  logic [3:0]        pix_q, pix_d;
  logic              pix_valid_q, pix_valid_d;
  logic              cpu_ack_q, cpu_ack_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [15:0]       ram_wdata_q, ram_wdata_d;
  logic              ram_we_q, ram_we_d;

  // Slot decode and CPU grant
  logic       v_active_c;
  logic       fetch_slot_c;
  logic       grant_c;
  logic [1:0] col_lo_c;

  always_comb begin
    v_active_c   = (VC >= VBP_C) && (VC < VFP_C);
    fetch_slot_c = v_active_c && (HC >= SLOT_LO) && (HC < SLOT_HI) &&
                   (HC[1:0] == 2'b00);
    // ACK still high means REQ is the request just served, not a new one
    grant_c      = CPU_REQ && !fetch_slot_c && !cpu_ack_q;
    col_lo_c     = HC[1:0] - HBP_LO;
  end

  // Next-state logic for fetch address, read pipeline, pixel path and RAM port
  always_comb begin
    faddr_d     = faddr_q;
    slot_p1_d   = fetch_slot_c;
    slot_p2_d   = slot_p1_q;
    hold_d      = hold_q;
    shift_d     = shift_q;
    pix_d       = 4'h0;
    pix_valid_d = VIDON;
    cpu_ack_d   = 1'b0;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    ram_we_d    = 1'b0;

    // Frame address restarts during vertical back porch
    if (VC < VBP_C) begin
      faddr_d = '0;
    end else if (fetch_slot_c) begin
      faddr_d = (faddr_q == LAST_WORD) ? '0 : faddr_q + ADDR_W'(1);
    end

    // Two edges after a slot the RAM word is on RAM_RDATA
    if (slot_p2_q) begin
      hold_d = RAM_RDATA;
    end

    // First column of each group takes the fresh word, others shift out
    if (VIDON) begin
      if (col_lo_c == 2'b00) begin
        pix_d   = hold_q[15:12];
        shift_d = hold_q[11:0];
      end else begin
        pix_d   = shift_q[11:8];
        shift_d = {shift_q[7:0], 4'h0};
      end
    end

    // Display fetch has priority; CPU waits at most one extra edge
    if (fetch_slot_c) begin
      ram_addr_d = faddr_q;
    end else if (grant_c) begin
      cpu_ack_d   = 1'b1;
      ram_addr_d  = CPU_ADDR;
      ram_wdata_d = CPU_WDATA;
      ram_we_d    = ({1'b0, CPU_ADDR} < WORDS_C);
    end
  end

  // State register with synchronous reset
  always_ff @(posedge CLK) begin
    if (!CLR_N) begin
      faddr_q     <= '0;
      slot_p1_q   <= 1'b0;
      slot_p2_q   <= 1'b0;
      hold_q      <= '0;
      shift_q     <= '0;
      pix_q       <= '0;
      pix_valid_q <= 1'b0;
      cpu_ack_q   <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      ram_we_q    <= 1'b0;
    end else begin
      faddr_q     <= faddr_d;
      slot_p1_q   <= slot_p1_d;
      slot_p2_q   <= slot_p2_d;
      hold_q      <= hold_d;
      shift_q     <= shift_d;
      pix_q       <= pix_d;
      pix_valid_q <= pix_valid_d;
      cpu_ack_q   <= cpu_ack_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      ram_we_q    <= ram_we_d;
    end
  end

  assign CPU_ACK   = cpu_ack_q;
  assign RAM_ADDR  = ram_addr_q;
  assign RAM_WDATA = ram_wdata_q;
  assign RAM_WE    = ram_we_q;
  assign PIX       = pix_q;
  assign PIX_VALID = pix_valid_q;

  // Handshake invariants
  a_ack_single : assert property (@(posedge CLK) disable iff (!CLR_N)
                                  cpu_ack_q |=> !cpu_ack_q);
  a_we_has_ack : assert property (@(posedge CLK) disable iff (!CLR_N)
                                  ram_we_q |-> cpu_ack_q);

endmodule
